// File: rtl/vedic_product_divider_if.sv
// Operand/result handshake bundle for the restoring divider.
// The master drives the operands and out_ready; the slave returns results.
interface vedic_product_divider_if #(
   parameter int DIVIDEND_WIDTH = 8,
   parameter int DIVISOR_WIDTH  = 4
);
   logic                      in_valid;
   logic                      in_ready;
   logic [DIVIDEND_WIDTH-1:0] dividend_in;
   logic [DIVISOR_WIDTH-1:0]  divisor_in;
   logic                      out_valid;
   logic                      out_ready;
   logic [DIVIDEND_WIDTH-1:0] quotient_out;
   logic [DIVISOR_WIDTH-1:0]  remainder_out;
   logic                      div_by_zero;
   logic                      exact_out;

   modport master (
      output in_valid, dividend_in, divisor_in, out_ready,
      input  in_ready, out_valid, quotient_out, remainder_out, div_by_zero, exact_out
   );

   modport slave (
      input  in_valid, dividend_in, divisor_in, out_ready,
      output in_ready, out_valid, quotient_out, remainder_out, div_by_zero, exact_out
   );
endinterface

// File: rtl/vedic_product_divider.sv
// Sequential radix-2 restoring divider: one quotient bit per cycle, MSB first,
// with valid/ready on both sides and a one-cycle divide-by-zero shortcut.
module vedic_product_divider #(
   parameter int DIVIDEND_WIDTH = 8,
   parameter int DIVISOR_WIDTH  = 4
) (
   input logic                   clk,
   input logic                   rst,
   vedic_product_divider_if.slave bus
);
   localparam int CW = (DIVIDEND_WIDTH > 1) ? $clog2(DIVIDEND_WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                    state;
   logic [CW-1:0]             cnt;
   logic [DIVIDEND_WIDTH-1:0] dvd;
   logic [DIVISOR_WIDTH-1:0]  dvs;
   logic [DIVISOR_WIDTH:0]    pr;
   logic [DIVIDEND_WIDTH-1:0] q;

   logic [DIVISOR_WIDTH:0]    pr_shift;
   logic [DIVISOR_WIDTH:0]    trial;
   logic [DIVISOR_WIDTH:0]    pr_next;
   logic [DIVIDEND_WIDTH-1:0] q_next;

   // The extra partial-remainder bit only carries the borrow of the trial subtract.
   always_comb begin
      pr_shift    = {pr[DIVISOR_WIDTH-1:0], dvd[cnt]};
      trial       = pr_shift - {1'b0, dvs};
      pr_next     = trial[DIVISOR_WIDTH] ? pr_shift : trial;
      q_next      = q;
      q_next[cnt] = ~trial[DIVISOR_WIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         cnt               <= '0;
         dvd               <= '0;
         dvs               <= '0;
         pr                <= '0;
         q                 <= '0;
         bus.in_ready      <= 1'b1;
         bus.out_valid     <= 1'b0;
         bus.quotient_out  <= '0;
         bus.remainder_out <= '0;
         bus.div_by_zero   <= 1'b0;
         bus.exact_out     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  dvd          <= bus.dividend_in;
                  dvs          <= bus.divisor_in;
                  bus.in_ready <= 1'b0;
                  if (bus.divisor_in == '0) begin
                     state             <= DONE;
                     bus.out_valid     <= 1'b1;
                     bus.quotient_out  <= '1;
                     bus.remainder_out <= bus.dividend_in[DIVISOR_WIDTH-1:0];
                     bus.div_by_zero   <= 1'b1;
                     bus.exact_out     <= 1'b0;
                  end else begin
                     pr    <= '0;
                     cnt   <= CW'(DIVIDEND_WIDTH-1);
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               pr <= pr_next;
               q  <= q_next;
               if (cnt == '0) begin
                  state             <= DONE;
                  bus.out_valid     <= 1'b1;
                  bus.quotient_out  <= q_next;
                  bus.remainder_out <= pr_next[DIVISOR_WIDTH-1:0];
                  bus.div_by_zero   <= 1'b0;
                  bus.exact_out     <= (pr_next[DIVISOR_WIDTH-1:0] == '0);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               // in_ready only returns after the consume edge, so no accept overlaps it.
               if (bus.out_ready) begin
                  state             <= IDLE;
                  bus.in_ready      <= 1'b1;
                  bus.out_valid     <= 1'b0;
                  bus.quotient_out  <= '0;
                  bus.remainder_out <= '0;
                  bus.div_by_zero   <= 1'b0;
                  bus.exact_out     <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vedic_product_divider.sv
// Directed bench for vedic_product_divider: arithmetic reference model plus
// literal expectations, latency, backpressure, reset-abort and inverse sweep.
module tb_vedic_product_divider;
   localparam int DW = 8;
   localparam int SW = 4;

   typedef struct {
      logic [DW-1:0] q;
      logic [SW-1:0] r;
      logic          dbz;
      logic          ex;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vedic_product_divider_if #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW)) bus ();

   vedic_product_divider #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int   checks = 0;
   int   errors = 0;
   int   hs_cnt = 0;
   bit   done   = 0;
   res_t exp_q[$];
   res_t last;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic res_t model(input logic [DW-1:0] a, input logic [SW-1:0] b);
      res_t m;
      if (b == 0) begin
         m.q = '1; m.r = a[SW-1:0]; m.dbz = 1'b1; m.ex = 1'b0;
      end else begin
         m.q = DW'(int'(a) / int'(b));
         m.r = SW'(int'(a) % int'(b));
         m.dbz = 1'b0;
         m.ex = (m.r == 0);
      end
      return m;
   endfunction

   // One op: wait for in_ready, present operands, then consume the result.
   task automatic op(input logic [DW-1:0] a, input logic [SW-1:0] b, input int exp_lat,
                     input int hold, input bit noise, input bit rnd,
                     input int eq, input int er, input int eex, input int edbz);
      int cyc, lat, got_lat, vcyc, t0;
      cyc = 0;
      while (!bus.in_ready && cyc < 100) begin
         @(posedge clk); #1; cyc++;
      end
      if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
      bus.in_valid = 1'b1; bus.dividend_in = a; bus.divisor_in = b;
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      t0 = hs_cnt; lat = 1; got_lat = -1; vcyc = 0; cyc = 0;
      while (hs_cnt == t0 && cyc < 200) begin
         if (bus.out_valid && got_lat < 0) got_lat = lat;
         if (bus.out_valid) vcyc++;
         if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
         else     bus.out_ready = bus.out_valid && (vcyc > hold);
         if (noise && !bus.out_ready) begin
            bus.in_valid    = 1'($urandom_range(0, 1));
            bus.dividend_in = 8'($urandom);
            bus.divisor_in  = 4'($urandom);
         end else begin
            bus.in_valid = 1'b0;
         end
         @(posedge clk); #1; cyc++; lat++;
      end
      bus.out_ready = 1'b0; bus.in_valid = 1'b0;
      if (hs_cnt == t0) chk("result_timeout", 0, 1);
      if (exp_lat > 0) chk("latency", got_lat, exp_lat);
      if (hold > 0) chk("hold_cycles", vcyc, hold + 1);
      chk("quotient_lit", int'(last.q), eq);
      chk("remainder_lit", int'(last.r), er);
      chk("exact_lit", int'(last.ex), eex);
      chk("dbz_lit", int'(last.dbz), edbz);
      chk("in_ready_after_hs", int'(bus.in_ready), 1);
      chk("out_valid_after_hs", int'(bus.out_valid), 0);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
      chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
      chk({tag, "_quotient"}, int'(bus.quotient_out), 0);
      chk({tag, "_remainder"}, int'(bus.remainder_out), 0);
      chk({tag, "_dbz"}, int'(bus.div_by_zero), 0);
      chk({tag, "_exact"}, int'(bus.exact_out), 0);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.dividend_in = '0; bus.divisor_in = '0;
      fork
         // Compare process: sampled on the falling edge, away from the active edge.
         begin
            while (!done) begin
               @(negedge clk);
               if (rst) begin
                  exp_q.delete();
               end else begin
                  if (bus.in_ready)
                     chk("idle_outputs_zero",
                         int'({bus.out_valid, bus.quotient_out, bus.remainder_out,
                               bus.div_by_zero, bus.exact_out}), 0);
                  if (bus.out_valid) begin
                     if (exp_q.size() == 0) begin
                        chk("spurious_result", 1, 0);
                     end else begin
                        chk("model_quotient", int'(bus.quotient_out), int'(exp_q[0].q));
                        chk("model_remainder", int'(bus.remainder_out), int'(exp_q[0].r));
                        chk("model_dbz", int'(bus.div_by_zero), int'(exp_q[0].dbz));
                        chk("model_exact", int'(bus.exact_out), int'(exp_q[0].ex));
                        if (bus.out_ready) begin
                           last.q = bus.quotient_out; last.r = bus.remainder_out;
                           last.dbz = bus.div_by_zero; last.ex = bus.exact_out;
                           void'(exp_q.pop_front());
                        end
                     end
                     if (bus.out_ready) hs_cnt++;
                  end
                  if (bus.in_valid && bus.in_ready)
                     exp_q.push_back(model(bus.dividend_in, bus.divisor_in));
               end
            end
         end
         begin
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            chk_idle("reset");

            op(8'd225, 4'd15, 9, 0, 0, 0, 15, 0, 1, 0);
            op(8'd200, 4'd7,  9, 0, 0, 0, 28, 4, 0, 0);
            op(8'd255, 4'd1,  9, 0, 0, 0, 255, 0, 1, 0);
            op(8'd100, 4'd0,  1, 0, 0, 0, 255, 4, 0, 1);
            op(8'd77,  4'd5,  9, 6, 1, 0, 15, 2, 0, 0);
            repeat (4) @(posedge clk);
            #1 chk("no_second_result", hs_cnt, 5);

            // Abort a 250/3 in the middle of CALC.
            bus.in_valid = 1'b1; bus.dividend_in = 8'd250; bus.divisor_in = 4'd3;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            repeat (4) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            chk_idle("abort");
            op(8'd250, 4'd3, 9, 0, 0, 0, 83, 1, 0, 0);

            for (int a = 1; a <= 15; a++)
               for (int b = 1; b <= 15; b++)
                  op(8'(a * b), 4'(b), -1, 0, 0, 1, a, 0, 1, 0);

            repeat (3) @(posedge clk);
            #1 chk("scoreboard_empty", exp_q.size(), 0);
            done = 1'b1;
         end
      join
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
